prbs_pattern_gen: RTL
=====================

# prbs_pattern_gen

Frame transmitter for the PRBS-15 test link. On a start pulse it emits the header pattern 0x0A, 0x0B, 0x0C, 0x0D repeated `n` times, then `PRBS_LEN` PRBS-15 bytes. Output is a registered byte stream with a valid/ready handshake. It sits at the source end of the link, driving the downstream pattern detector in loopback and system tests.

## Interface
- `PATT_WIDTH`, 8: byte width; only 8 is supported.
- `REPEAT_WIDTH`, 5: width of `n`.
- `PRBS_LEN`, 16: PRBS bytes per frame; legal range 1..255.
- `PRBS_SEED`, 15'h7FFF: LFSR seed loaded at every start; a value of 0 is replaced by 15'h7FFF.
- `clk` in 1: single clock, rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `start` in 1: frame request, accepted in IDLE only.
- `n` in REPEAT_WIDTH: header repeat count, latched on accepted start.
- `byte_ready` in 1: downstream ready.
- `byte_out` out PATT_WIDTH: current byte.
- `byte_valid` out 1: `byte_out` is valid.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last PRBS byte transfers.

## Operation
- States:
  - IDLE: waits for `start`.
  - HDR: byte index 0..3 and repeat counter.
  - PRBS: byte counter.
- IDLE + `start`:
  - Latch `n`, load LFSR with seed, clear counters.
  - Go to HDR, or to PRBS directly if `n`==0.
- Transfer occurs on a cycle with `byte_valid && byte_ready`. With no transfer, `byte_out` and `byte_valid` hold stable; stall length is unbounded.
- HDR sequencing:
  - Each transfer advances the index 0A→0B→0C→0D→0A.
  - A transfer of 0D increments the repeat counter.
  - When the counter reaches the latched `n`, the next byte is the first PRBS byte.
- LFSR:
  - Polynomial x^15+x^14+1. One step: fb = lfsr[14]^lfsr[13]; lfsr = {lfsr[13:0], fb}.
  - One PRBS byte = 8 steps. The first fb goes to bit 7, the last to bit 0.
  - The LFSR advances only on transfer of a PRBS byte, and never during HDR.
- PRBS ends when transfer number `PRBS_LEN` completes. The block then returns to IDLE, `done`=1 for that cycle, and `busy`=0.
- `start` is ignored while `busy`=1, including the `done` cycle. A `start` in the cycle after `done` is accepted.
- Counters do not wrap: the repeat counter is REPEAT_WIDTH bits, and the byte counter is 8 bits.

## Timing
- Reset values: `byte_out`=0, `byte_valid`=0, `busy`=0, `done`=0, state IDLE, LFSR=seed.
- Reset mid-frame aborts immediately. No `done` is produced, and any partial frame is discarded.
- Start latency: `start` high at edge k makes `byte_valid`=1, `busy`=1 and the first byte visible after edge k.
- Throughput is 1 byte/cycle while `byte_ready`=1.
- `byte_valid` stays high continuously from the first byte through the last PRBS byte. It drops in the cycle `done` is high.
- All outputs are registered, with no combinational path from `byte_ready` to any output.

## Configuration
- `PRBS_PATT_GEN_ERR_INJ_EN` defined:
  - Adds input `err_inj` (1 bit).
  - A high sample sets a sticky flag. The next header byte presented is XORed with 8'h80.
  - The flag clears on that byte's transfer. `err_inj` while the flag is set has no further effect.
  - The flag clears in IDLE and on reset. PRBS bytes are never corrupted.
- `PRBS_PATT_GEN_ERR_INJ_EN` not defined: the port and flag logic are absent, and the stream is always clean.

## Structure
- Package `prbs_pkg`:
  - Header byte constants `HDR_A..HDR_D` (0A..0D).
  - State encoding typedef.
  - `PRBS15_DEFAULT_SEED` (15'h7FFF) and tap positions (14, 13).
- Sub-module `lfsr15_byte`: combinational 8-step advance; 15-bit state in, next state and byte out. It is reused by the PRBS checker.

## Test plan
- Reset, `n`=2, `PRBS_LEN`=2, `byte_ready`=1, `start` pulse → bytes 0A 0B 0C 0D 0A 0B 0C 0D 00 02 on consecutive cycles, then a single `done` pulse; `busy` high for exactly 10 cycles.
- `n`=0, `PRBS_LEN`=3 → first byte 00, second 02, third 0x(next); no header bytes emitted.
- `n`=1, `byte_ready` toggling 1,0,0,1,… → `byte_out` holds during stalls; the sequence matches the unstalled stream byte-for-byte.
- `start` pulsed mid-frame and in the `done` cycle → ignored; `start` one cycle after `done` → new frame, and PRBS restarts at 00 02.
- `arst` asserted during PRBS byte 1 → outputs 0 immediately, no `done`; the next frame is identical to the first.
- With `PRBS_PATT_GEN_ERR_INJ_EN`: `err_inj` before the first byte → first byte 8A, rest clean; without the macro → first byte 0A.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS-15 pattern generator and checker.
package prbs_pkg;

  localparam logic [7:0] HDR_A = 8'h0A;
  localparam logic [7:0] HDR_B = 8'h0B;
  localparam logic [7:0] HDR_C = 8'h0C;
  localparam logic [7:0] HDR_D = 8'h0D;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPrbs
  } state_e;

  localparam logic [14:0] PRBS15_DEFAULT_SEED = 15'h7FFF;
  localparam int unsigned PRBS15_TAP_HI = 14;
  localparam int unsigned PRBS15_TAP_LO = 13;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = HDR_A;
      2'd1:    b = HDR_B;
      2'd2:    b = HDR_C;
      default: b = HDR_D;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs_pattern_gen_lfsr15_byte.sv
// Combinational 8-step advance of the x^15+x^14+1 LFSR; first feedback bit lands in byte bit 7.
module lfsr15_byte
  import prbs_pkg::*;
(
  input  logic [14:0] state_i,
  output logic [14:0] state_o,
  output logic [7:0]  byte_o
);

  logic [14:0] s;
  logic        fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      fb            = s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
      byte_o[7 - i] = fb;
      s             = {s[13:0], fb};
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_pattern_gen.sv
// PRBS-15 frame transmitter: header 0A..0D repeated n times, then PRBS_LEN PRBS bytes.
// Optional header error injection is enabled by defining PRBS_PATT_GEN_ERR_INJ_EN.
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter int unsigned PATT_WIDTH   = 8,
  parameter int unsigned REPEAT_WIDTH = 5,
  parameter int unsigned PRBS_LEN     = 16,
  parameter logic [14:0] PRBS_SEED    = 15'h7FFF
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] n,
  input  logic                    byte_ready,
`ifdef PRBS_PATT_GEN_ERR_INJ_EN
  input  logic                    err_inj,
`endif
  output logic [PATT_WIDTH-1:0]   byte_out,
  output logic                    byte_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [14:0] SeedEff = (PRBS_SEED == 15'd0) ? PRBS15_DEFAULT_SEED : PRBS_SEED;
  localparam logic [7:0]  LastCnt = 8'(PRBS_LEN - 1);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d, n_q, n_d, rep_inc;
  logic [7:0]              cnt_q, cnt_d;
  logic [14:0]             lfsr_q, lfsr_d, gen_in, gen_next;
  logic [7:0]              gen_byte, byte_q, byte_d, inj_mask;
  logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic                    xfer, accept, err_now, hit_cur, hdr_next;

  // lfsr_q holds the state following the PRBS byte currently presented.
  assign gen_in = (state_q == StIdle) ? SeedEff : lfsr_q;

  lfsr15_byte u_lfsr (
    .state_i (gen_in),
    .state_o (gen_next),
    .byte_o  (gen_byte)
  );

  assign xfer     = valid_q & byte_ready;
  assign accept   = (state_q == StIdle) & start & ~done_q;
  assign rep_inc  = rep_q + 1'b1;
  assign inj_mask = (err_now & ~hit_cur) ? 8'h80 : 8'h00;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hdr_next = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          n_d     = n;
          idx_d   = 2'd0;
          rep_d   = '0;
          cnt_d   = 8'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (n == '0) begin
            state_d = StPrbs;
            byte_d  = gen_byte;
            lfsr_d  = gen_next;
          end else begin
            state_d  = StHdr;
            byte_d   = HDR_A ^ inj_mask;
            lfsr_d   = SeedEff;
            hdr_next = 1'b1;
          end
        end
      end
      StHdr: begin
        if (xfer) begin
          if (idx_q == 2'd3) begin
            rep_d = rep_inc;
            idx_d = 2'd0;
            if (rep_inc == n_q) begin
              state_d = StPrbs;
              byte_d  = gen_byte;
              lfsr_d  = gen_next;
            end else begin
              byte_d   = HDR_A ^ inj_mask;
              hdr_next = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 2'd1;
            byte_d   = hdr_byte(idx_q + 2'd1) ^ inj_mask;
            hdr_next = 1'b1;
          end
        end
      end
      StPrbs: begin
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_d = gen_byte;
            lfsr_d = gen_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PRBS_PATT_GEN_ERR_INJ_EN
  // flag_q: injection pending or in flight; hit_q: the presented byte carries it.
  logic flag_q, flag_d, hit_q, hit_d;

  assign err_now = flag_q | err_inj;
  assign hit_cur = hit_q;

  always_comb begin
    flag_d = flag_q | err_inj;
    hit_d  = hit_q;
    if (state_q == StIdle) begin
      flag_d = hdr_next & err_inj;
      hit_d  = hdr_next & err_inj;
    end else if (xfer) begin
      if (hit_q) begin
        flag_d = 1'b0;
        hit_d  = 1'b0;
      end else begin
        flag_d = err_now;
        hit_d  = err_now & hdr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      flag_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      hit_q  <= hit_d;
    end
  end
`else
  assign err_now = 1'b0;
  assign hit_cur = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      rep_q   <= '0;
      n_q     <= '0;
      cnt_q   <= 8'd0;
      lfsr_q  <= SeedEff;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
